he_lpbk_csr_regfile: RTL and testbench

HE_LPBK_CSR_REGFILE -- requirements
Module: he_lpbk_csr_regfile

---
 rtl/he_lpbk_csr_regfile.sv | 245 ++++++++++++++++++++++++
 tb/tb_he_lpbk_csr_regfile.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/he_lpbk_csr_regfile.sv
`timescale 1ns/1ps
// MMIO control/status register file for the host-exerciser loopback engine.
// Write side is always accepted; read side is a two-state FSM returning one
// registered response per accepted request.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | rd_ready high, waiting for a read request
// S_RSP  | response held on rsp_* until rsp_ready consumes it
module he_lpbk_csr_regfile #(
    parameter int          ADDR_W   = 20,
    parameter logic [63:0] DFH_VAL  = 64'h1000_0000_0000_1001,
    parameter logic [63:0] ID_L_VAL = 64'h0,
    parameter logic [63:0] ID_H_VAL = 64'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_len32,
    input  logic [63:0]       wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [9:0]        rd_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [9:0]        rsp_tag,
    output logic [63:0]       rsp_data,
    output logic [63:0]       src_addr,
    output logic [63:0]       dst_addr,
    output logic [31:0]       num_lines,
    output logic [63:0]       cfg,
    output logic [31:0]       inact_thresh,
    output logic [31:0]       stride,
    output logic [63:0]       dsm_base,
    output logic              eng_rst,
    output logic              start,
    input  logic [63:0]       stat0_in,
    input  logic [63:0]       stat1_in,
    input  logic [63:0]       err_in
);

    localparam logic [ADDR_W-1:0] A_DFH    = ADDR_W'(12'h000);
    localparam logic [ADDR_W-1:0] A_ID_L   = ADDR_W'(12'h008);
    localparam logic [ADDR_W-1:0] A_ID_H   = ADDR_W'(12'h010);
    localparam logic [ADDR_W-1:0] A_SP     = ADDR_W'(12'h100);
    localparam logic [ADDR_W-1:0] A_SP_HI  = ADDR_W'(12'h104);
    localparam logic [ADDR_W-1:0] A_SP2    = ADDR_W'(12'h108);
    localparam logic [ADDR_W-1:0] A_DSM    = ADDR_W'(12'h110);
    localparam logic [ADDR_W-1:0] A_DSM_HI = ADDR_W'(12'h114);
    localparam logic [ADDR_W-1:0] A_SRC    = ADDR_W'(12'h120);
    localparam logic [ADDR_W-1:0] A_DST    = ADDR_W'(12'h128);
    localparam logic [ADDR_W-1:0] A_NUM    = ADDR_W'(12'h130);
    localparam logic [ADDR_W-1:0] A_CTL    = ADDR_W'(12'h138);
    localparam logic [ADDR_W-1:0] A_CFG    = ADDR_W'(12'h140);
    localparam logic [ADDR_W-1:0] A_INACT  = ADDR_W'(12'h148);
    localparam logic [ADDR_W-1:0] A_INT0   = ADDR_W'(12'h150);
    localparam logic [ADDR_W-1:0] A_SWT    = ADDR_W'(12'h158);
    localparam logic [ADDR_W-1:0] A_STAT0  = ADDR_W'(12'h160);
    localparam logic [ADDR_W-1:0] A_STAT1  = ADDR_W'(12'h168);
    localparam logic [ADDR_W-1:0] A_ERR    = ADDR_W'(12'h170);
    localparam logic [ADDR_W-1:0] A_STRIDE = ADDR_W'(12'h178);

    typedef enum logic {S_IDLE, S_RSP} state_t;

    state_t      state_q, state_d;
    logic        rd_accept;
    logic [63:0] rd_mux;

    logic [31:0] sp0_q, sp1_q, sp2_q, dsm_lo_q, dsm_hi_q;
    logic [63:0] src_q, dst_q, ctl_q, cfg_q, int0_q, swt_q, err_q;
    logic [19:0] num_q;
    logic [31:0] inact_q, stride_q;
    logic        eng_rst_q, start_q;

    // Every register lives in an 8-byte slot. Bit 0 enables the low word,
    // bit 1 the high word. A 64-bit write must be slot-aligned and hits both
    // halves; a 32-bit write hits the half selected by byte offset 0 or 4.
    function automatic logic [1:0] slot_we(input logic              v,
                                           input logic [ADDR_W-1:0] a,
                                           input logic              len32,
                                           input logic [ADDR_W-1:0] base);
        logic hit;
        logic lo;
        logic hi;
        hit = v && (a[ADDR_W-1:3] == base[ADDR_W-1:3]);
        lo  = hit && (a[2:0] == 3'd0);
        hi  = hit && (len32 ? (a[2:0] == 3'd4) : (a[2:0] == 3'd0));
        return {hi, lo};
    endfunction

    logic [1:0]  we_sp, we_sp2, we_dsm, we_src, we_dst, we_num, we_ctl;
    logic [1:0]  we_cfg, we_inact, we_int0, we_swt, we_err, we_stride;
    logic [31:0] wr_lo, wr_hi;
    logic [63:0] err_clr;

    assign wr_lo     = wr_data[31:0];
    assign wr_hi     = wr_len32 ? wr_data[31:0] : wr_data[63:32];

    assign we_sp     = slot_we(wr_valid, wr_addr, wr_len32, A_SP);
    assign we_sp2    = slot_we(wr_valid, wr_addr, wr_len32, A_SP2);
    assign we_dsm    = slot_we(wr_valid, wr_addr, wr_len32, A_DSM);
    assign we_src    = slot_we(wr_valid, wr_addr, wr_len32, A_SRC);
    assign we_dst    = slot_we(wr_valid, wr_addr, wr_len32, A_DST);
    assign we_num    = slot_we(wr_valid, wr_addr, wr_len32, A_NUM);
    assign we_ctl    = slot_we(wr_valid, wr_addr, wr_len32, A_CTL);
    assign we_cfg    = slot_we(wr_valid, wr_addr, wr_len32, A_CFG);
    assign we_inact  = slot_we(wr_valid, wr_addr, wr_len32, A_INACT);
    assign we_int0   = slot_we(wr_valid, wr_addr, wr_len32, A_INT0);
    assign we_swt    = slot_we(wr_valid, wr_addr, wr_len32, A_SWT);
    assign we_err    = slot_we(wr_valid, wr_addr, wr_len32, A_ERR);
    assign we_stride = slot_we(wr_valid, wr_addr, wr_len32, A_STRIDE);

    assign err_clr = {(we_err[1] ? wr_hi : 32'h0), (we_err[0] ? wr_lo : 32'h0)};

    // Writable registers, sticky error bits, start pulse and engine reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp0_q     <= '0;
            sp1_q     <= '0;
            sp2_q     <= '0;
            dsm_lo_q  <= '0;
            dsm_hi_q  <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            num_q     <= '0;
            ctl_q     <= '0;
            cfg_q     <= '0;
            inact_q   <= '0;
            int0_q    <= '0;
            swt_q     <= '0;
            err_q     <= '0;
            stride_q  <= '0;
            eng_rst_q <= 1'b1;
            start_q   <= 1'b0;
        end else begin
            if (we_sp[0])     sp0_q           <= wr_lo;
            if (we_sp[1])     sp1_q           <= wr_hi;
            if (we_sp2[0])    sp2_q           <= wr_lo;
            if (we_dsm[0])    dsm_lo_q        <= wr_lo;
            if (we_dsm[1])    dsm_hi_q        <= wr_hi;
            if (we_src[0])    src_q[31:0]     <= wr_lo;
            if (we_src[1])    src_q[63:32]    <= wr_hi;
            if (we_dst[0])    dst_q[31:0]     <= wr_lo;
            if (we_dst[1])    dst_q[63:32]    <= wr_hi;
            if (we_num[0])    num_q           <= wr_lo[19:0];
            if (we_cfg[0])    cfg_q[31:0]     <= wr_lo;
            if (we_cfg[1])    cfg_q[63:32]    <= wr_hi;
            if (we_inact[0])  inact_q         <= wr_lo;
            if (we_int0[0])   int0_q[31:0]    <= wr_lo;
            if (we_int0[1])   int0_q[63:32]   <= wr_hi;
            if (we_swt[0])    swt_q[31:0]     <= wr_lo;
            if (we_swt[1])    swt_q[63:32]    <= wr_hi;
            if (we_stride[0]) stride_q        <= wr_lo;
            // CTL[1] is a self-clearing trigger, so it is never stored.
            if (we_ctl[0]) begin
                ctl_q[31:0] <= {wr_lo[31:2], 1'b0, wr_lo[0]};
                eng_rst_q   <= ~wr_lo[0];
            end
            if (we_ctl[1])    ctl_q[63:32]    <= wr_hi;
            start_q <= we_ctl[0] && wr_lo[1] && wr_lo[0];
            // Clear is applied before set so a same-cycle event wins.
            err_q   <= (err_q & ~err_clr) | err_in;
        end
    end

    // Read data mux over current (pre-write) register contents.
    always_comb begin
        rd_mux = 64'h0;
        case (rd_addr)
            A_DFH:    rd_mux = DFH_VAL;
            A_ID_L:   rd_mux = ID_L_VAL;
            A_ID_H:   rd_mux = ID_H_VAL;
            A_SP:     rd_mux = {sp1_q, sp0_q};
            A_SP_HI:  rd_mux = {32'h0, sp1_q};
            A_SP2:    rd_mux = {32'h0, sp2_q};
            A_DSM:    rd_mux = {dsm_hi_q, dsm_lo_q};
            A_DSM_HI: rd_mux = {32'h0, dsm_hi_q};
            A_SRC:    rd_mux = src_q;
            A_DST:    rd_mux = dst_q;
            A_NUM:    rd_mux = {44'h0, num_q};
            A_CTL:    rd_mux = ctl_q;
            A_CFG:    rd_mux = cfg_q;
            A_INACT:  rd_mux = {32'h0, inact_q};
            A_INT0:   rd_mux = int0_q;
            A_SWT:    rd_mux = swt_q;
            A_STAT0:  rd_mux = stat0_in;
            A_STAT1:  rd_mux = stat1_in;
            A_ERR:    rd_mux = err_q;
            A_STRIDE: rd_mux = {32'h0, stride_q};
            default:  rd_mux = 64'h0;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Read FSM next state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        rd_ready  = 1'b0;
        rsp_valid = 1'b0;
        rd_accept = 1'b0;
        case (state_q)
            S_IDLE: begin
                rd_ready = 1'b1;
                if (rd_valid) begin
                    rd_accept = 1'b1;
                    state_d   = S_RSP;
                end
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Response capture; held untouched while the response waits.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_tag  <= '0;
            rsp_data <= '0;
        end else if (rd_accept) begin
            rsp_tag  <= rd_tag;
            rsp_data <= rd_mux;
        end
    end

    assign src_addr     = src_q;
    assign dst_addr     = dst_q;
    assign num_lines    = {12'h0, num_q};
    assign cfg          = cfg_q;
    assign inact_thresh = inact_q;
    assign stride       = stride_q;
    assign dsm_base     = {dsm_hi_q, dsm_lo_q};
    assign eng_rst      = eng_rst_q;
    assign start        = start_q;

endmodule

// File: tb/tb_he_lpbk_csr_regfile.sv
`timescale 1ns/1ps
// Bench for he_lpbk_csr_regfile: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a slot-array model.
module tb_he_lpbk_csr_regfile;

    localparam logic [63:0] DFH = 64'h1000_0000_0000_1001;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic [19:0] wr_addr;
    logic        wr_len32;
    logic [63:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [19:0] rd_addr;
    logic [9:0]  rd_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [9:0]  rsp_tag;
    logic [63:0] rsp_data;
    logic [63:0] src_addr, dst_addr, cfg, dsm_base;
    logic [31:0] num_lines, inact_thresh, stride;
    logic        eng_rst, start;
    logic [63:0] stat0_in, stat1_in, err_in;

    he_lpbk_csr_regfile dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_len32(wr_len32), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_tag(rd_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
        .src_addr(src_addr), .dst_addr(dst_addr), .num_lines(num_lines), .cfg(cfg),
        .inact_thresh(inact_thresh), .stride(stride), .dsm_base(dsm_base),
        .eng_rst(eng_rst), .start(start),
        .stat0_in(stat0_in), .stat1_in(stat1_in), .err_in(err_in)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: one 64-bit value per 8-byte slot
    logic [63:0] m [64];
    logic [63:0] m_err;
    bit          busy;
    logic [9:0]  e_tag;
    logic [63:0] e_data;
    bit          e_start;
    bit          model_ok = 0;

    // Bits that survive a write, by slot index (0 = read-only / unmapped).
    function automatic logic [63:0] wmask(input logic [5:0] idx);
        case (idx)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h28, 6'h2A, 6'h2B: return 64'hFFFF_FFFF_FFFF_FFFF;
            6'h21, 6'h29, 6'h2F:                             return 64'h0000_0000_FFFF_FFFF;
            6'h26:                                           return 64'h0000_0000_000F_FFFF;
            6'h27:                                           return ~64'h2;
            default:                                         return 64'h0;
        endcase
    endfunction

    function automatic logic [63:0] m_read(input logic [19:0] a);
        logic [5:0] idx;
        idx = a[8:3];
        if (a >= 20'h200 || a[1:0] != 2'b00) return 64'h0;
        if (a[2]) return (a == 20'h104 || a == 20'h114) ? (m[idx] >> 32) : 64'h0;
        case (a)
            20'h000: return DFH;
            20'h160: return stat0_in;
            20'h168: return stat1_in;
            20'h170: return m_err;
            default: return m[idx];
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic [5:0]  idx;
        logic [63:0] v;
        logic [63:0] c;
        if (rst) begin
            for (int i = 0; i < 64; i++) m[i] = 64'h0;
            m_err    = 64'h0;
            busy     = 0;
            e_start  = 0;
            model_ok = 1;
        end else if (model_ok) begin
            if (!busy) begin
                if (rd_valid) begin
                    e_tag  = rd_tag;
                    e_data = m_read(rd_addr);
                    busy   = 1;
                end
            end else if (rsp_ready) begin
                busy = 0;
            end
            e_start = 0;
            if (wr_valid && wr_addr < 20'h200 && wr_addr[1:0] == 2'b00 && (wr_len32 || !wr_addr[2])) begin
                idx = wr_addr[8:3];
                if (wr_len32) c = wr_addr[2] ? {wr_data[31:0], 32'h0} : {32'h0, wr_data[31:0]};
                else          c = wr_data;
                if (idx == 6'h2E) begin
                    m_err = m_err & ~c;
                end else begin
                    v = m[idx];
                    if (!wr_len32)     v = wr_data;
                    else if (wr_addr[2]) v[63:32] = wr_data[31:0];
                    else               v[31:0] = wr_data[31:0];
                    m[idx] = v & wmask(idx);
                    if (idx == 6'h27 && !wr_addr[2] && wr_data[0] && wr_data[1]) e_start = 1;
                end
            end
            m_err = m_err | err_in;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("rd_ready", 64'(rd_ready), 64'(!busy));
            chk("rsp_valid", 64'(rsp_valid), 64'(busy));
            if (busy) begin
                chk("rsp_tag", 64'(rsp_tag), 64'(e_tag));
                chk("rsp_data", rsp_data, e_data);
            end
            chk("src_addr", src_addr, m[6'h24]);
            chk("dst_addr", dst_addr, m[6'h25]);
            chk("num_lines", 64'(num_lines), m[6'h26]);
            chk("cfg", cfg, m[6'h28]);
            chk("inact_thresh", 64'(inact_thresh), m[6'h29]);
            chk("stride", 64'(stride), m[6'h2F]);
            chk("dsm_base", dsm_base, m[6'h22]);
            chk("eng_rst", 64'(eng_rst), 64'(!m[6'h27][0]));
            chk("start", 64'(start), 64'(e_start));
        end
    end

    // ---------------- stimulus helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [19:0] a, input logic len32, input logic [63:0] d);
        wr_valid = 1'b1; wr_addr = a; wr_len32 = len32; wr_data = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [19:0] a, input logic [9:0] t,
                           output logic [63:0] d, output logic [9:0] tg);
        rd_valid = 1'b1; rd_addr = a; rd_tag = t;
        tick();
        rd_valid = 1'b0;
        chk("rsp_valid_after_accept", 64'(rsp_valid), 64'h1);
        d  = rsp_data;
        tg = rsp_tag;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    logic [19:0] addr_tab [27];
    logic [63:0] rdat;
    logic [9:0]  rtag;
    int          pulses;

    initial begin
        addr_tab = '{20'h000, 20'h008, 20'h010, 20'h100, 20'h104, 20'h108, 20'h10C,
                     20'h110, 20'h114, 20'h120, 20'h128, 20'h130, 20'h138, 20'h13C,
                     20'h140, 20'h148, 20'h150, 20'h154, 20'h158, 20'h160, 20'h168,
                     20'h170, 20'h174, 20'h178, 20'h180, 20'h1F8, 20'h70120};
        rst = 1'b1; wr_valid = 0; wr_addr = 0; wr_len32 = 0; wr_data = 0;
        rd_valid = 0; rd_addr = 0; rd_tag = 0; rsp_ready = 0;
        stat0_in = 64'h0123_4567_89AB_CDEF; stat1_in = 64'hFEDC_BA98_7654_3210; err_in = 0;
        tick(); tick(); tick();
        chk("reset_rd_ready", 64'(rd_ready), 64'h1);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("reset_eng_rst", 64'(eng_rst), 64'h1);
        chk("reset_src", src_addr, 64'h0);
        rst = 1'b0;
        tick();

        do_read(20'h000, 10'h2A, rdat, rtag);
        chk("dfh_data", rdat, 64'h1000_0000_0000_1001);
        chk("dfh_tag", 64'(rtag), 64'h2A);

        do_write(20'h104, 1'b1, 64'h0000_0000_DEAD_BEEF);
        do_read(20'h100, 10'h1, rdat, rtag);
        chk("scratch_pair", rdat, 64'hDEAD_BEEF_0000_0000);

        do_read(20'h168, 10'h2, rdat, rtag);
        chk("status1_live", rdat, 64'hFEDC_BA98_7654_3210);

        do_write(20'h138, 1'b0, 64'h1);
        chk("ctl1_eng_rst", 64'(eng_rst), 64'h0);
        chk("ctl1_no_start", 64'(start), 64'h0);
        wr_valid = 1'b1; wr_addr = 20'h138; wr_len32 = 1'b0; wr_data = 64'h3;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            wr_valid = 1'b0;
            if (start) pulses++;
        end
        chk("start_pulse_count", 64'(pulses), 64'h1);
        do_read(20'h138, 10'h3, rdat, rtag);
        chk("ctl_readback", rdat, 64'h1);

        err_in = 64'h10;
        tick();
        err_in = 64'h0;
        do_read(20'h170, 10'h4, rdat, rtag);
        chk("error_set", rdat, 64'h10);
        do_write(20'h170, 1'b0, 64'h10);
        do_read(20'h170, 10'h5, rdat, rtag);
        chk("error_clear", rdat, 64'h0);
        err_in = 64'h10; wr_valid = 1'b1; wr_addr = 20'h170; wr_len32 = 1'b0; wr_data = 64'h10;
        tick();
        err_in = 64'h0; wr_valid = 1'b0;
        do_read(20'h170, 10'h6, rdat, rtag);
        chk("error_set_wins", rdat, 64'h10);
        do_write(20'h170, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);

        do_write(20'h120, 1'b0, 64'h1111_2222_3333_4444);
        rd_valid = 1'b1; rd_addr = 20'h120; rd_tag = 10'h7;
        wr_valid = 1'b1; wr_addr = 20'h120; wr_len32 = 1'b0; wr_data = 64'h5555_6666_7777_8888;
        tick();
        rd_valid = 1'b0; wr_valid = 1'b0;
        chk("raw_pre_write_data", rsp_data, 64'h1111_2222_3333_4444);
        chk("raw_src_updated", src_addr, 64'h5555_6666_7777_8888);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        rd_valid = 1'b1; rd_addr = 20'h120; rd_tag = 10'h3C1;
        tick();
        rd_addr = 20'h000; rd_tag = 10'h155;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 64'(rsp_valid), 64'h1);
            chk("hold_data", rsp_data, 64'h5555_6666_7777_8888);
            chk("hold_tag", 64'(rsp_tag), 64'h3C1);
            chk("hold_rd_ready", 64'(rd_ready), 64'h0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("idle_rd_ready", 64'(rd_ready), 64'h1);
        chk("idle_rsp_valid", 64'(rsp_valid), 64'h0);
        tick();
        rd_valid = 1'b0;
        chk("second_valid", 64'(rsp_valid), 64'h1);
        chk("second_tag", 64'(rsp_tag), 64'h155);
        chk("second_data", rsp_data, 64'h1000_0000_0000_1001);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        do_write(20'h130, 1'b0, 64'hFFFF_FFFF);
        chk("num_lines_mask", 64'(num_lines), 64'h000F_FFFF);
        do_write(20'h140, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5);
        do_write(20'h110, 1'b0, 64'h1234_5678_9ABC_DEF0);
        chk("dsm_pair", dsm_base, 64'h1234_5678_9ABC_DEF0);
        rd_valid = 1'b1; rd_addr = 20'h130; rd_tag = 10'h1;
        tick();
        rd_valid = 1'b0;
        chk("pre_rst_valid", 64'(rsp_valid), 64'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rd_ready", 64'(rd_ready), 64'h1);
        chk("rst_src", src_addr, 64'h0);
        chk("rst_num_lines", 64'(num_lines), 64'h0);
        chk("rst_cfg", cfg, 64'h0);
        chk("rst_dsm", dsm_base, 64'h0);
        chk("rst_eng_rst", 64'(eng_rst), 64'h1);

        for (int k = 0; k < 3000; k++) begin
            rst       = ($urandom_range(0, 399) == 0);
            wr_valid  = 1'($urandom_range(0, 1));
            wr_addr   = addr_tab[$urandom_range(0, 26)];
            wr_len32  = wr_addr[2] ? 1'b1 : 1'($urandom_range(0, 1));
            wr_data   = {$urandom, $urandom};
            rd_valid  = 1'($urandom_range(0, 1));
            rd_addr   = addr_tab[$urandom_range(0, 26)];
            rd_tag    = 10'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 6);
            stat0_in  = {$urandom, $urandom};
            stat1_in  = {$urandom, $urandom};
            err_in    = ($urandom_range(0, 3) == 0) ? (64'h1 << $urandom_range(0, 63)) : 64'h0;
            tick();
        end

        rst = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1; err_in = 64'h0;
        tick(); tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
